// File: rtl/arr_idx_write_stage_pkg.sv
// rtl/arr_idx_write_stage_pkg.sv - shared types, defaults and index classifier for the indexed write stage
package arr_idx_pkg;

   // Default index range of the array front-end; instances override LO/HI.
   localparam int unsigned DEFAULT_LO = 1;
   localparam int unsigned DEFAULT_HI = 2;
   localparam int unsigned DEPTH      = DEFAULT_HI - DEFAULT_LO + 1;

   // Classifier operand width; callers zero-extend their index into it.
   localparam int unsigned CLASS_IDX_W = 32;

   typedef enum logic [1:0] {
      IDX_OK,
      IDX_OOR,
      IDX_UNDEF
   } idx_class_t;

   // Unknown bits win over range; the offset carries one extra bit so an
   // index below lo shows up as negative instead of wrapping into range.
   function automatic idx_class_t classify_idx(
      input logic [CLASS_IDX_W-1:0] idx,
      input int unsigned            lo,
      input int unsigned            hi
   );
      logic [CLASS_IDX_W:0] off;
      logic [CLASS_IDX_W:0] span;
      idx_class_t           result;
      off  = {1'b0, idx} - {1'b0, lo};
      span = {1'b0, hi} - {1'b0, lo};
      if ($isunknown(^idx)) begin
         result = IDX_UNDEF;
      end else if (off[CLASS_IDX_W] || (off > span)) begin
         result = IDX_OOR;
      end else begin
         result = IDX_OK;
      end
      return result;
   endfunction

endpackage

// File: rtl/arr_idx_write_stage_if.sv
// rtl/arr_idx_write_stage_if.sv - write/read/status bundle of the indexed write stage
interface arr_idx_write_stage_if #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 8
);

   logic             wr_valid;
   logic             wr_ready;
   logic [IDX_W-1:0] wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [IDX_W-1:0] rd_idx;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_oor;
   logic [CNT_W-1:0] oor_count;
   logic [CNT_W-1:0] undef_count;
   logic             drop_sticky;

   // Requester side: issues writes and reads, observes status.
   modport master (
      output wr_valid, wr_idx, wr_data, rd_en, rd_idx,
      input  wr_ready, rd_data, rd_valid, rd_oor, oor_count, undef_count, drop_sticky
   );

   // Stage side.
   modport slave (
      input  wr_valid, wr_idx, wr_data, rd_en, rd_idx,
      output wr_ready, rd_data, rd_valid, rd_oor, oor_count, undef_count, drop_sticky
   );

endinterface

// File: rtl/arr_idx_write_stage_sat_counter.sv
// rtl/arr_idx_write_stage_sat_counter.sv - saturating event counter for dropped writes
module arr_idx_sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Count up on inc, sticking at all-ones so a burst never wraps to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/arr_idx_write_stage.sv
// rtl/arr_idx_write_stage.sv - range-checked indexed write pipeline and read port for a [HI:LO] word array
module arr_idx_write_stage
   import arr_idx_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned LO    = 1,
   parameter int unsigned HI    = 2,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   arr_idx_write_stage_if.slave bus
);

   localparam int unsigned MEM_DEPTH = HI - LO + 1;
   localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [WIDTH-1:0] mem [MEM_DEPTH];

   logic             s1_valid;
   logic [IDX_W-1:0] s1_idx;
   logic [WIDTH-1:0] s1_data;
   logic             s1_done;
   logic             s1_commit;
   idx_class_t       s1_class;
   logic [AW-1:0]    s1_addr;

   idx_class_t       rd_class;
   logic [AW-1:0]    rd_addr;

   logic             accept;
   logic             inc_oor;
   logic             inc_undef;

   // Classification uses the wide offset arithmetic in the package; the
   // narrow address below is only used once the index is known to be legal.
   assign s1_class = classify_idx(CLASS_IDX_W'(s1_idx), LO, HI);
   assign rd_class = classify_idx(CLASS_IDX_W'(bus.rd_idx), LO, HI);
   assign s1_addr  = AW'(s1_idx - IDX_W'(LO));
   assign rd_addr  = AW'(bus.rd_idx - IDX_W'(LO));

   // S1 resolves every request in a single cycle, so it never backs up S0.
   assign s1_done      = s1_valid;
   assign s1_commit    = s1_valid && (s1_class == IDX_OK);
   assign inc_oor      = s1_valid && (s1_class == IDX_OOR);
   assign inc_undef    = s1_valid && (s1_class == IDX_UNDEF);
   assign bus.wr_ready = !rst && (!s1_valid || s1_done);
   assign accept       = bus.wr_valid && bus.wr_ready;

   // S0 -> S1 register: capture the accepted request, empty once it resolves.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_data  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_idx   <= bus.wr_idx;
         s1_data  <= bus.wr_data;
      end else if (s1_done) begin
         s1_valid <= 1'b0;
      end
   end

   // Array storage: only a legal S1 request may touch an entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (s1_commit) begin
         mem[s1_addr] <= s1_data;
      end
   end

   // Registered read: sees the array before a same-edge commit (no bypass).
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_oor   <= 1'b0;
      end else if (bus.rd_en) begin
         bus.rd_valid <= 1'b1;
         if (rd_class == IDX_OK) begin
            bus.rd_data <= mem[rd_addr];
            bus.rd_oor  <= 1'b0;
         end else begin
            bus.rd_data <= '0;
            bus.rd_oor  <= 1'b1;
         end
      end else begin
         bus.rd_valid <= 1'b0;
         bus.rd_oor   <= 1'b0;
      end
   end

   // Sticky flag records that at least one write was dropped since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.drop_sticky <= 1'b0;
      end else if (inc_oor || inc_undef) begin
         bus.drop_sticky <= 1'b1;
      end
   end

   arr_idx_sat_counter #(
      .CNT_W (CNT_W)
   ) u_oor_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_oor),
      .count (bus.oor_count)
   );

   arr_idx_sat_counter #(
      .CNT_W (CNT_W)
   ) u_undef_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_undef),
      .count (bus.undef_count)
   );

endmodule

// File: tb/tb_arr_idx_write_stage.sv
// tb/tb_arr_idx_write_stage.sv - self-checking bench for arr_idx_write_stage
module tb_arr_idx_write_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic [3:0] wr_idx;
   logic [1:0] wr_data;
   logic       rd_en;
   logic [3:0] rd_idx;

   always #5 clk = ~clk;

   arr_idx_write_stage_if #(.WIDTH(2), .IDX_W(4), .CNT_W(2)) ifa ();
   arr_idx_write_stage_if #(.WIDTH(2), .IDX_W(4), .CNT_W(8)) ifb ();

   assign ifa.wr_valid = wr_valid;
   assign ifa.wr_idx   = wr_idx;
   assign ifa.wr_data  = wr_data;
   assign ifa.rd_en    = rd_en;
   assign ifa.rd_idx   = rd_idx;
   assign ifb.wr_valid = wr_valid;
   assign ifb.wr_idx   = wr_idx;
   assign ifb.wr_data  = wr_data;
   assign ifb.rd_en    = rd_en;
   assign ifb.rd_idx   = rd_idx;

   arr_idx_write_stage #(.WIDTH(2), .LO(1), .HI(2), .IDX_W(4), .CNT_W(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   arr_idx_write_stage #(.WIDTH(2), .LO(0), .HI(1), .IDX_W(4), .CNT_W(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   logic [31:0] o_rd [2];
   logic [31:0] o_rv [2];
   logic [31:0] o_oor[2];
   logic [31:0] o_oc [2];
   logic [31:0] o_uc [2];
   logic [31:0] o_st [2];
   logic [31:0] o_wr [2];

   assign o_rd[0]  = 32'(ifa.rd_data);
   assign o_rv[0]  = 32'(ifa.rd_valid);
   assign o_oor[0] = 32'(ifa.rd_oor);
   assign o_oc[0]  = 32'(ifa.oor_count);
   assign o_uc[0]  = 32'(ifa.undef_count);
   assign o_st[0]  = 32'(ifa.drop_sticky);
   assign o_wr[0]  = 32'(ifa.wr_ready);
   assign o_rd[1]  = 32'(ifb.rd_data);
   assign o_rv[1]  = 32'(ifb.rd_valid);
   assign o_oor[1] = 32'(ifb.rd_oor);
   assign o_oc[1]  = 32'(ifb.oor_count);
   assign o_uc[1]  = 32'(ifb.undef_count);
   assign o_st[1]  = 32'(ifb.drop_sticky);
   assign o_wr[1]  = 32'(ifb.wr_ready);

   int total = 0;
   int bad   = 0;

   // Reference model: per instance, the array addressed by absolute index,
   // drop counters and expected read-port state.
   int lo_m [2] = '{1, 0};
   int hi_m [2] = '{2, 1};
   int cmax [2] = '{3, 255};
   int mem_m[2][16];
   int oc   [2];
   int uc   [2];
   int st   [2];
   int erd  [2];
   int erv  [2];
   int eoor [2];
   bit         pv;
   logic [3:0] pidx;
   logic [1:0] pdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // 0 = legal, 1 = out of range, 2 = unknown bits
   function automatic int cls(input logic [3:0] idx, input int k);
      if ($isunknown(idx)) return 2;
      if (int'(idx) < lo_m[k] || int'(idx) > hi_m[k]) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mem_m[k][i] = 0;
         oc[k] = 0; uc[k] = 0; st[k] = 0;
         erd[k] = 0; erv[k] = 0; eoor[k] = 0;
      end
      pv = 1'b0;
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_rd_data%0d", tag, k), o_rd[k], erd[k]);
         chk($sformatf("%s_rd_valid%0d", tag, k), o_rv[k], erv[k]);
         chk($sformatf("%s_rd_oor%0d", tag, k), o_oor[k], eoor[k]);
         chk($sformatf("%s_oor_count%0d", tag, k), o_oc[k], oc[k]);
         chk($sformatf("%s_undef_count%0d", tag, k), o_uc[k], uc[k]);
         chk($sformatf("%s_sticky%0d", tag, k), o_st[k], st[k]);
         chk($sformatf("%s_wr_ready%0d", tag, k), o_wr[k], 1);
      end
   endtask

   task automatic set_in(input logic v, input logic [3:0] wi, input logic [1:0] wd,
                         input logic re, input logic [3:0] ri);
      wr_valid = v; wr_idx = wi; wr_data = wd; rd_en = re; rd_idx = ri;
   endtask

   // One clock: the read sees the array before the pending write lands,
   // then the write accepted last cycle resolves, then this cycle's is queued.
   task automatic step(input string tag);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rd_en) begin
            erv[k] = 1;
            if (cls(rd_idx, k) == 0) begin
               erd[k] = mem_m[k][rd_idx]; eoor[k] = 0;
            end else begin
               erd[k] = 0; eoor[k] = 1;
            end
         end else begin
            erv[k] = 0; eoor[k] = 0;
         end
         if (pv) begin
            case (cls(pidx, k))
               0: mem_m[k][pidx] = int'(pdata);
               1: begin if (oc[k] < cmax[k]) oc[k]++; st[k] = 1; end
               default: begin if (uc[k] < cmax[k]) uc[k]++; st[k] = 1; end
            endcase
         end
      end
      pv = wr_valid; pidx = wr_idx; pdata = wr_data;
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_valid = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      model_reset();
      #1 rst = 1'b0;
      #1 check_all("reset");
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      @(posedge clk);
      do_reset();

      // Range check with nonzero LO
      set_in(1, 4'd1, 2'd1, 0, 0); step("p1_w1");
      set_in(1, 4'd2, 2'd2, 0, 0); step("p1_w2");
      set_in(1, 4'd0, 2'd0, 0, 0); step("p1_w0");
      set_in(1, 4'd3, 2'd3, 0, 0); step("p1_w3");
      set_in(0, 0, 0, 0, 0);       step("p1_idle");
      set_in(0, 0, 0, 1, 4'd2);    step("p1_r2");
      chk("p1_rd2_const", o_rd[0], 2);
      set_in(0, 0, 0, 1, 4'd1);    step("p1_r1");
      chk("p1_rd1_const", o_rd[0], 1);
      chk("p1_oor_const", o_oor[0], 0);
      set_in(0, 0, 0, 0, 0);       step("p1_end");
      chk("p1_oorcnt_const", o_oc[0], 2);
      chk("p1_undef_const", o_uc[0], 0);
      chk("p1_sticky_const", o_st[0], 1);

      // Read colliding with a commit returns the old value
      set_in(1, 4'd1, 2'd3, 0, 0); step("col_w");
      set_in(0, 0, 0, 1, 4'd1);    step("col_r_old");
      chk("col_old_const", o_rd[0], 1);
      set_in(0, 0, 0, 1, 4'd1);    step("col_r_new");
      chk("col_new_const", o_rd[0], 3);

      // Out-of-range and unknown reads
      set_in(0, 0, 0, 1, 4'd5);    step("rd_oor5");
      chk("rd5_oor_const", o_oor[0], 1);
      chk("rd5_data_const", o_rd[0], 0);
      chk("rd5_valid_const", o_rv[0], 1);
      set_in(0, 0, 0, 1, 4'bx1x0); step("rd_x");
      set_in(0, 0, 0, 0, 0);       step("rd_idle");
      chk("rd_idle_valid_const", o_rv[0], 0);

      // Unknown-index write
      set_in(1, 4'bxxxx, 2'd2, 0, 0); step("wx");
      set_in(0, 0, 0, 0, 0);          step("wx_idle");

      // Counter saturation
      for (int i = 0; i < 5; i++) begin
         set_in(1, 4'd3, 2'd1, 0, 0); step("sat_w");
      end
      set_in(0, 0, 0, 0, 0); step("sat_idle");
      chk("sat_const", o_oc[0], 3);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 1, 4'(i)); step("post_rst_rd");
      end

      // Reset while S1 holds a write
      set_in(1, 4'd2, 2'd3, 0, 0); step("mid_w");
      do_reset();
      set_in(0, 0, 0, 1, 4'd2);    step("mid_r");
      set_in(0, 0, 0, 0, 0);       step("mid_idle");
      chk("mid_oor_b_const", o_oc[1], 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 63) == 0) begin
            do_reset();
         end else begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_idx   = ($urandom_range(0, 15) == 0) ? 4'bxxxx : 4'($urandom_range(0, 5));
            wr_data  = 2'($urandom_range(0, 3));
            rd_en    = 1'($urandom_range(0, 1));
            rd_idx   = ($urandom_range(0, 15) == 0) ? 4'bxxxx : 4'($urandom_range(0, 5));
            step("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arr_idx_write_stage.md
Name: arr_idx_write_stage

Overview:
- Clocked write/read front-end for a small word array declared with an arbitrary index range [HI:LO].
- It sits directly upstream of the array-storage checks: it accepts indexed write requests and range-checks each index.
- Writes with an in-range index commit; writes whose index is out of range or contains X/Z bits are discarded and counted, never aliased onto another entry.
- It also provides a registered read port with the same out-of-range rule.

Parameters:
- WIDTH, 2, data word width in bits.
- LO, 1, lowest legal index (inclusive); may be nonzero.
- HI, 2, highest legal index (inclusive); HI >= LO required.
- IDX_W, 4, width of the index ports, interpreted as unsigned.
- CNT_W, 8, width of the drop counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  stage can accept a write.
- wr_idx  input  IDX_W  write index.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request.
- rd_idx  input  IDX_W  read index.
- rd_data  output  WIDTH  read data.
- rd_valid  output  1  rd_data valid, one cycle after rd_en.
- rd_oor  output  1  the read in flight had an out-of-range or X index.
- oor_count  output  CNT_W  saturating count of dropped out-of-range writes.
- undef_count  output  CNT_W  saturating count of dropped X/Z-index writes.
- drop_sticky  output  1  set on any dropped write; cleared only by rst.

Behaviour:
- Reset: every array entry <= 0. wr_ready=1, rd_data=0, rd_valid=0, rd_oor=0, both counters=0, drop_sticky=0. The S1 register is emptied.
- Write pipeline, two stages:
  - S0 accepts on wr_valid && wr_ready and latches idx/data into S1.
  - S1 classifies and acts on the next edge:
    - UNDEF: the reduction-XOR of idx is X.
    - OOR: idx < LO or idx > HI.
    - OK: otherwise; entry[idx] <= data.
  - Write latency: an accept at edge N commits at edge N+1.
- wr_ready = !s1_valid || s1_commits_this_cycle. S1 always completes in one cycle, so wr_ready is 1 except during rst. Back-to-back writes run at one per cycle.
- Dropped writes:
  - Never modify any entry.
  - Increment the matching counter, saturating at 2^CNT_W-1.
  - Set drop_sticky.
  - UNDEF takes precedence over OOR; a write is counted once only.
- Read:
  - rd_en at edge N samples rd_idx; rd_data/rd_valid/rd_oor are updated at edge N+1.
  - Legal index: rd_data = entry[rd_idx], rd_oor=0.
  - OOR or X index: rd_data = 0, rd_oor=1.
  - rd_valid=0 and rd_oor=0 in cycles without a prior rd_en. rd_data holds its last value.
- Read/write collision: a read sampled at the same edge as an S1 commit to the same index returns the OLD value (no bypass). The next read returns the new value.
- Two writes to the same index on consecutive cycles: the last one wins.
- Reset mid-operation: the S1 contents are discarded, not committed. A read in flight is cancelled (rd_valid=0).
- Index arithmetic: idx - LO is computed in IDX_W+1 bits to avoid wrap. Negative or over-HI results are OOR, never truncated into range.

Decomposition:
- Package arr_idx_pkg holds:
  - localparam DEPTH = HI-LO+1;
  - the enum idx_class_t {IDX_OK, IDX_OOR, IDX_UNDEF};
  - the function classify_idx(idx, lo, hi) returning idx_class_t.
- One sub-module, arr_idx_sat_counter (CNT_W, inc, rst, clk -> count), is instantiated twice.

Test Plan:
- LO=1,HI=2: write idx 1=2'd1, idx 2=2'd2, idx 0=2'd0, idx 3=2'd3; read 2 then 1 -> rd_data 2, then 1, rd_oor=0. oor_count=2, undef_count=0, drop_sticky=1.
- LO=0,HI=1: write idx 0=0, idx 1=1, idx 'bx=2 -> entries 0 and 1 are unchanged at 0/1. undef_count=1, oor_count=0.
- Read idx 5 and idx 4'bx1x0 -> rd_data=0, rd_oor=1, rd_valid=1 one cycle after each rd_en.
- Write idx 1=3 at edge N with a read of idx 1 sampled at edge N+1 -> returns old value 1. A read at N+2 returns 3.
- CNT_W=2: five OOR writes -> oor_count saturates at 3. Then rst -> all counters, entries and drop_sticky read 0.
- Assert rst while S1 holds a valid write to idx 2=3 -> after reset entry[2]=0 and wr_ready=1.
